// File: rtl/fbw_pkg.sv
// fbw_pkg: command codes, parser states and pixel geometry shared by the framebuffer write controller
package fbw_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_FILL = 8'h02;
  localparam int PIX_BYTES = 2;
  typedef enum logic [3:0] {
    S_CMD, S_X, S_Y, S_N, S_PLO, S_PHI, S_MEMW, S_CLO, S_CHI, S_FILL
  } state_t;
endpackage

// File: rtl/fb_write_ctrl_if.sv
// fb_write_ctrl_if: decoded-byte input, frame memory write port and status pulses
interface fb_write_ctrl_if #(parameter int ADDR_W = 16, parameter int PIX_W = 16);
  logic IN_FLAG;
  logic [7:0] IN_DATA;
  logic BUSY;
  logic MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [PIX_W-1:0] MEM_WDATA;
  logic MEM_ACK;
  logic DONE;
  logic ERR;
  logic OVF;
  modport master(input IN_FLAG, IN_DATA, MEM_ACK,
                 output BUSY, MEM_WE, MEM_ADDR, MEM_WDATA, DONE, ERR, OVF);
  modport slave(output IN_FLAG, IN_DATA, MEM_ACK,
                input BUSY, MEM_WE, MEM_ADDR, MEM_WDATA, DONE, ERR, OVF);
endinterface

// File: rtl/fbw_addr_gen.sv
// fbw_addr_gen: loads Y*H_RES+X and steps the pixel word address modulo 2^ADDR_W
module fbw_addr_gen #(
  parameter int H_RES = 256,
  parameter int ADDR_W = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic inc,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [ADDR_W-1:0] addr
);
  localparam int SH = $clog2(H_RES);
  always_ff @(posedge CLK)
    addr <= !RST ? '0 : load ? (ADDR_W'(y) << SH) + ADDR_W'(x) : inc ? addr + ADDR_W'(1) : addr;
endmodule

// File: rtl/fb_write_ctrl.sv
// fb_write_ctrl: byte-command parser driving framebuffer pixel writes; FB_WRITE_CTRL_STATS_EN adds saturating stats counters
module fb_write_ctrl
  import fbw_pkg::*;
#(
  parameter int H_RES = 256,
  parameter int ADDR_W = 16,
  parameter int PIX_W = 8 * PIX_BYTES
) (
  input  logic CLK,
  input  logic RST,
  fb_write_ctrl_if.master m
`ifdef FB_WRITE_CTRL_STATS_EN
  ,
  output logic [31:0] PIX_CNT,
  output logic [15:0] ERR_CNT,
  output logic [15:0] OVF_CNT
`endif
);
  state_t state, state_n;
  logic fill, fill_n, we, we_n, done, done_n, err, err_n, ovf, ovf_n;
  logic load, inc, ack, take;
  logic [7:0] x, x_n, lo, lo_n;
  logic [8:0] cnt, cnt_n;
  logic [PIX_W-1:0] wdata, wdata_n;
  logic [ADDR_W-1:0] addr;

  fbw_addr_gen #(.H_RES(H_RES), .ADDR_W(ADDR_W)) u_addr (
    .CLK(CLK), .RST(RST), .load(load), .inc(inc), .x(x), .y(m.IN_DATA), .addr(addr)
  );

  assign m.BUSY = we;
  assign m.MEM_WE = we;
  assign m.MEM_ADDR = addr;
  assign m.MEM_WDATA = wdata;
  assign m.DONE = done;
  assign m.ERR = err;
  assign m.OVF = ovf;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= S_CMD;
      fill <= 1'b0;
      we <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      ovf <= 1'b0;
      x <= '0;
      lo <= '0;
      cnt <= '0;
      wdata <= '0;
    end else begin
      state <= state_n;
      fill <= fill_n;
      we <= we_n;
      done <= done_n;
      err <= err_n;
      ovf <= ovf_n;
      x <= x_n;
      lo <= lo_n;
      cnt <= cnt_n;
      wdata <= wdata_n;
    end
  end

  // a byte is only consumed while no write is pending; otherwise it is dropped as an overflow
  always_comb begin
    state_n = state;
    fill_n = fill;
    we_n = we;
    x_n = x;
    lo_n = lo;
    cnt_n = cnt;
    wdata_n = wdata;
    done_n = 1'b0;
    err_n = 1'b0;
    load = 1'b0;
    inc = 1'b0;
    ack = we && m.MEM_ACK;
    take = m.IN_FLAG && !we;
    ovf_n = m.IN_FLAG && we;
    case (state)
      S_CMD: if (take) begin
        state_n = (m.IN_DATA == CMD_WRITE || m.IN_DATA == CMD_FILL) ? S_X : S_CMD;
        fill_n = m.IN_DATA == CMD_FILL;
        err_n = m.IN_DATA != CMD_WRITE && m.IN_DATA != CMD_FILL;
      end
      S_X: if (take) begin
        x_n = m.IN_DATA;
        state_n = S_Y;
      end
      S_Y: if (take) begin
        load = 1'b1;
        state_n = S_N;
      end
      S_N: if (take) begin
        cnt_n = m.IN_DATA == 8'd0 ? 9'd256 : {1'b0, m.IN_DATA};
        state_n = fill ? S_CLO : S_PLO;
      end
      S_PLO, S_CLO: if (take) begin
        lo_n = m.IN_DATA;
        state_n = state == S_PLO ? S_PHI : S_CHI;
      end
      S_PHI, S_CHI: if (take) begin
        wdata_n = PIX_W'({m.IN_DATA, lo});
        we_n = 1'b1;
        state_n = state == S_PHI ? S_MEMW : S_FILL;
      end
      S_MEMW, S_FILL: if (ack) begin
        inc = 1'b1;
        cnt_n = cnt - 9'd1;
        we_n = state == S_FILL && cnt != 9'd1;
        done_n = cnt == 9'd1;
        state_n = cnt == 9'd1 ? S_CMD : state == S_FILL ? S_FILL : S_PLO;
      end
      default: state_n = S_CMD;
    endcase
  end

`ifdef FB_WRITE_CTRL_STATS_EN
  always_ff @(posedge CLK) begin
    if (!RST) begin
      PIX_CNT <= '0;
      ERR_CNT <= '0;
      OVF_CNT <= '0;
    end else begin
      PIX_CNT <= PIX_CNT + 32'(ack && !(&PIX_CNT));
      ERR_CNT <= ERR_CNT + 16'(err_n && !(&ERR_CNT));
      OVF_CNT <= OVF_CNT + 16'(ovf_n && !(&OVF_CNT));
    end
  end
`endif
endmodule

// File: tb/tb_fb_write_ctrl.sv
// tb_fb_write_ctrl: directed command packets checked against a packet-level write model
module tb_fb_write_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  fb_write_ctrl_if #(.ADDR_W(16), .PIX_W(16)) bus ();
`ifdef FB_WRITE_CTRL_STATS_EN
  logic [31:0] pix_cnt;
  logic [15:0] err_cnt_o, ovf_cnt_o;
`endif

  fb_write_ctrl #(.H_RES(256), .ADDR_W(16), .PIX_W(16)) dut (
    .CLK(CLK), .RST(RST), .m(bus)
`ifdef FB_WRITE_CTRL_STATS_EN
    , .PIX_CNT(pix_cnt), .ERR_CNT(err_cnt_o), .OVF_CNT(ovf_cnt_o)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0] stim[$];
  int done_cnt = 0, err_cnt = 0, ovf_cnt = 0, busy_cnt = 0;
  int s_done, s_err, s_ovf, s_busy;
  int ack_delay = 0;
  bit spur = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // expected (addr, data) writes derived directly from the packet rules
  task automatic model();
    int i, n, base;
    logic [7:0] c;
    logic [15:0] d;
    i = 0;
    d = '0;
    while (i < stim.size()) begin
      c = stim[i];
      i++;
      if (c == 8'h01 || c == 8'h02) begin
        base = int'(stim[i+1]) * 256 + int'(stim[i]);
        n = stim[i+2] == 8'h00 ? 256 : int'(stim[i+2]);
        i += 3;
        if (c == 8'h02) begin
          d = {stim[i+1], stim[i]};
          i += 2;
        end
        for (int k = 0; k < n; k++) begin
          if (c == 8'h01) begin
            d = {stim[i+1], stim[i]};
            i += 2;
          end
          exp_q.push_back({16'(base + k), d});
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int t = 0; t < 1000 && bus.BUSY; t++) begin
      @(posedge CLK);
      #1;
    end
    chk("send_wait_busy", bus.BUSY, 1'b0);
    bus.IN_FLAG = 1'b1;
    bus.IN_DATA = b;
    @(posedge CLK);
    #1;
    bus.IN_FLAG = 1'b0;
  endtask

  task automatic send_all();
    foreach (stim[j]) send_byte(stim[j]);
  endtask

  task automatic snap();
    s_done = done_cnt;
    s_err = err_cnt;
    s_ovf = ovf_cnt;
    s_busy = busy_cnt;
  endtask

  task automatic finish_test(input string nm, input int ed, input int ee, input int eo, input int eb);
    for (int t = 0; t < 3000 && (exp_q.size() != 0 || bus.MEM_WE); t++) begin
      @(posedge CLK);
      #1;
    end
    chk({nm, "_drain"}, exp_q.size(), 0);
    repeat (3) @(posedge CLK);
    #1;
    chk({nm, "_done"}, done_cnt - s_done, ed);
    chk({nm, "_err"}, err_cnt - s_err, ee);
    chk({nm, "_ovf"}, ovf_cnt - s_ovf, eo);
    chk({nm, "_busy"}, busy_cnt - s_busy, eb);
  endtask

  initial begin
    int w;
    w = 0;
    bus.MEM_ACK = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (bus.MEM_WE) begin
        bus.MEM_ACK = w == ack_delay;
        w = w == ack_delay ? 0 : w + 1;
      end else begin
        bus.MEM_ACK = spur;
        w = 0;
      end
    end
  end

  initial begin
    logic pw, pa, pd, pe, po;
    logic [15:0] paddr, pdata;
    logic [31:0] e;
    pw = 0; pa = 0; pd = 0; pe = 0; po = 0; paddr = '0; pdata = '0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        exp_q.delete();
        pw = 0; pa = 0; pd = 0; pe = 0; po = 0;
      end else begin
        if (bus.MEM_WE && pw && !pa) begin
          chk("hold_addr", bus.MEM_ADDR, paddr);
          chk("hold_data", bus.MEM_WDATA, pdata);
        end
        if (bus.MEM_WE && bus.MEM_ACK) begin
          if (exp_q.size() == 0) chk("unexpected_write", bus.MEM_ADDR, 32'hDEAD_BEEF);
          else begin
            e = exp_q.pop_front();
            chk("wr_addr", bus.MEM_ADDR, e[31:16]);
            chk("wr_data", bus.MEM_WDATA, e[15:0]);
          end
        end
        chk("busy_vs_we", bus.BUSY, bus.MEM_WE);
        chk("done_width", bus.DONE & pd, 1'b0);
        chk("err_width", bus.ERR & pe, 1'b0);
        chk("ovf_width", bus.OVF & po, 1'b0);
        done_cnt += int'(bus.DONE);
        err_cnt += int'(bus.ERR);
        ovf_cnt += int'(bus.OVF);
        busy_cnt += int'(bus.BUSY);
        pw = bus.MEM_WE;
        pa = bus.MEM_WE && bus.MEM_ACK;
        pd = bus.DONE;
        pe = bus.ERR;
        po = bus.OVF;
        paddr = bus.MEM_ADDR;
        pdata = bus.MEM_WDATA;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.IN_FLAG = 1'b0;
    bus.IN_DATA = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_we", bus.MEM_WE, 1'b0);
    chk("rst_busy", bus.BUSY, 1'b0);
    chk("rst_done", bus.DONE, 1'b0);
    chk("rst_err", bus.ERR, 1'b0);
    chk("rst_ovf", bus.OVF, 1'b0);
    chk("rst_addr", bus.MEM_ADDR, 16'h0000);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;

    stim = '{8'h01, 8'h10, 8'h02, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56};
    model();
    chk("t1_model_0", exp_q[0], {16'h0210, 16'h1234});
    chk("t1_model_1", exp_q[1], {16'h0211, 16'h5678});
    snap();
    send_all();
    finish_test("t1", 1, 0, 0, 2);

    stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
    model();
    chk("t2_model_n", exp_q.size(), 256);
    chk("t2_model_first", exp_q[0], {16'h0000, 16'hFFFF});
    chk("t2_model_last", exp_q[255], {16'h00FF, 16'hFFFF});
    snap();
    send_all();
    finish_test("t2", 1, 0, 0, 256);

    ack_delay = 3;
    stim = '{8'h01, 8'h05, 8'h03, 8'h01, 8'hCD, 8'hAB};
    model();
    chk("t3_model_0", exp_q[0], {16'h0305, 16'hABCD});
    snap();
    send_all();
    finish_test("t3", 1, 0, 0, 4);
    ack_delay = 0;

    spur = 1'b1;
    stim = '{8'h7E, 8'h01, 8'hFF, 8'hFF, 8'h02, 8'hAA, 8'h55, 8'hBB, 8'h66};
    model();
    chk("t4_model_0", exp_q[0], {16'hFFFF, 16'h55AA});
    chk("t4_model_1", exp_q[1], {16'h0000, 16'h66BB});
    snap();
    send_all();
    finish_test("t4", 1, 1, 0, 2);
    spur = 1'b0;

    ack_delay = 1;
    stim = '{8'h02, 8'h00, 8'h01, 8'h04, 8'h34, 8'h12};
    model();
    snap();
    send_all();
    chk("t5_busy_at_strobe", bus.BUSY, 1'b1);
    bus.IN_FLAG = 1'b1;
    bus.IN_DATA = 8'h01;
    @(posedge CLK);
    #1;
    bus.IN_FLAG = 1'b0;
    stim = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h11, 8'h11};
    model();
    send_all();
    finish_test("t5", 2, 0, 1, 10);
    ack_delay = 0;

    stim = '{8'h02, 8'h00, 8'h10, 8'h00, 8'h11, 8'h22};
    model();
    send_all();
    repeat (10) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("t6_rst_we", bus.MEM_WE, 1'b0);
    chk("t6_rst_busy", bus.BUSY, 1'b0);
    chk("t6_rst_done", bus.DONE, 1'b0);
    chk("t6_abandoned", exp_q.size(), 0);
    snap();
    @(posedge CLK);
    #1;
    stim = '{8'h01, 8'h20, 8'h00, 8'h01, 8'hEF, 8'hBE};
    model();
    chk("t6_model_0", exp_q[0], {16'h0020, 16'hBEEF});
    send_all();
    finish_test("t6", 1, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
